// File: rtl/powlib_busarb.sv
// powlib_busarb: round-robin arbiter merging B_WRS masters onto one FIFO write port, with optional burst hold
module powlib_busarb #(
    parameter int B_WRS = 4,
    parameter int B_AW = 2,
    parameter int B_DW = 4,
    parameter int HOLD = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [B_WRS*B_DW-1:0] wrdatas,
    input  logic [B_WRS*B_AW-1:0] wraddrs,
    input  logic [B_WRS-1:0]      wrvlds,
    output logic [B_WRS-1:0]      wrrdys,
    output logic [B_DW-1:0]       rddata,
    output logic [B_AW-1:0]       rdaddr,
    output logic                  rdvld,
    input  logic                  rdnf
);
    localparam int PW = (B_WRS > 1) ? $clog2(B_WRS) : 1;
    localparam int CW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
    typedef enum logic {ARB, LOCK} state_t;
    state_t state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d, own_q, own_d, idx, win, cur;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [B_WRS-1:0] gnt;
    logic found, xfer, rdvld_q, rdvld_d;
    logic [B_DW-1:0] rddata_q, rddata_d;
    logic [B_AW-1:0] rdaddr_q, rdaddr_d;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(B_WRS - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        idx = ptr_q;
        found = 1'b0;
        win = ptr_q;
        for (int j = 0; j < B_WRS; j++) begin
            if (!found && wrvlds[idx]) begin
                found = 1'b1;
                win = idx;
            end
            idx = inc(idx);
        end
        cur = (state_q == LOCK) ? own_q : win;
        gnt = ((state_q == LOCK) ? wrvlds[own_q] : found) ? B_WRS'(1) << cur : '0;
        wrrdys = (rst || rdnf) ? '0 : gnt;
        xfer = |wrrdys;
        rdvld_d = xfer;
        rddata_d = rddata_q;
        rdaddr_d = rdaddr_q;
        for (int i = 0; i < B_WRS; i++) begin
            if (wrrdys[i]) begin
                rddata_d = wrdatas[i*B_DW +: B_DW];
                rdaddr_d = wraddrs[i*B_AW +: B_AW];
            end
        end
        state_d = state_q;
        ptr_d = ptr_q;
        own_d = own_q;
        cnt_d = cnt_q;
        if (state_q == ARB) begin
            if (xfer && HOLD == 1) ptr_d = inc(win);
            else if (xfer) begin
                state_d = LOCK;
                own_d = win;
                cnt_d = CW'(1);
            end
        end else if (!rdnf) begin
            // owner dropping valid releases the grant with a single bubble cycle
            if (wrvlds[own_q]) cnt_d = cnt_q + 1'b1;
            if (!wrvlds[own_q] || cnt_q + 1'b1 == CW'(HOLD)) begin
                state_d = ARB;
                ptr_d = inc(own_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            ptr_q <= '0;
            own_q <= '0;
            cnt_q <= '0;
            rdvld_q <= 1'b0;
            rddata_q <= '0;
            rdaddr_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            own_q <= own_d;
            cnt_q <= cnt_d;
            rdvld_q <= rdvld_d;
            rddata_q <= rddata_d;
            rdaddr_q <= rdaddr_d;
        end
    end

    assign rdvld = rdvld_q;
    assign rddata = rddata_q;
    assign rdaddr = rdaddr_q;
endmodule

// File: tb/tb_powlib_busarb.sv
// tb_powlib_busarb: directed grant vectors with a queued scoreboard on the merged output of three arbiter configurations
module tb_powlib_busarb;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    int total = 0, bad = 0, cyc = 0;
    logic [3:0] va = '0, vb = '0, ra, rb, oda, odb, odc;
    logic [2:0] vc = '0, rc, nf = '0;
    logic [15:0] da, db;
    logic [11:0] dc;
    logic [1:0] oaa, oab, oac;
    logic ova, ovb, ovc;
    logic [6:0] qa[$], qb[$], qc[$];

    function automatic logic [3:0] dval(input int x, input int i, input int t);
        return 4'((x * 7 + i * 5 + t * 3) & 15);
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            da[i*4 +: 4] = dval(0, i, cyc);
            db[i*4 +: 4] = dval(1, i, cyc);
        end
        for (int i = 0; i < 3; i++) dc[i*4 +: 4] = dval(2, i, cyc);
    end

    powlib_busarb #(.B_WRS(4), .B_AW(2), .B_DW(4), .HOLD(1)) u_a (
        .clk(clk), .rst(rst), .wrdatas(da), .wraddrs(8'he4), .wrvlds(va), .wrrdys(ra),
        .rddata(oda), .rdaddr(oaa), .rdvld(ova), .rdnf(nf[0]));
    powlib_busarb #(.B_WRS(4), .B_AW(2), .B_DW(4), .HOLD(3)) u_b (
        .clk(clk), .rst(rst), .wrdatas(db), .wraddrs(8'he4), .wrvlds(vb), .wrrdys(rb),
        .rddata(odb), .rdaddr(oab), .rdvld(ovb), .rdnf(nf[1]));
    powlib_busarb #(.B_WRS(3), .B_AW(2), .B_DW(4), .HOLD(1)) u_c (
        .clk(clk), .rst(rst), .wrdatas(dc), .wraddrs(6'b100100), .wrvlds(vc), .wrrdys(rc),
        .rddata(odc), .rdaddr(oac), .rdvld(ovc), .rdnf(nf[2]));

    function automatic logic [6:0] expb(input int x, input logic [3:0] g);
        logic [1:0] m = '0;
        for (int i = 0; i < 4; i++) if (g[i]) m = 2'(i);
        return (g == '0) ? 7'd0 : {1'b1, m, dval(x, int'(m), cyc)};
    endfunction

    task automatic chk(input string nm, input logic [6:0] e, input logic v, input logic [1:0] a, input logic [3:0] d);
        total++;
        if (v !== e[6] || (e[6] && {a, d} !== e[5:0])) begin
            bad++;
            $display("FAIL out_%s t=%0t: got vld=%b addr=%0d data=%h, want vld=%b addr=%0d data=%h",
                     nm, $time, v, a, d, e[6], e[5:4], e[3:0]);
        end
    endtask

    always @(negedge clk) begin
        if (qa.size() > 0) chk("a", qa.pop_front(), ova, oaa, oda);
        if (qb.size() > 0) chk("b", qb.pop_front(), ovb, oab, odb);
        if (qc.size() > 0) chk("c", qc.pop_front(), ovc, oac, odc);
    end

    task automatic step(input int x, input logic [3:0] v, input logic n, input logic [3:0] er);
        logic [3:0] got;
        va = (x == 0) ? v : '0;
        vb = (x == 1) ? v : '0;
        vc = (x == 2) ? v[2:0] : '0;
        nf = '0;
        nf[x] = n;
        #1;
        got = (x == 0) ? ra : (x == 1) ? rb : {1'b0, rc};
        total++;
        if (got !== er) begin
            bad++;
            $display("FAIL wrrdys inst%0d cyc%0d: got %b want %b", x, cyc, got, er);
        end
        qa.push_back((x == 0) ? expb(0, er) : 7'd0);
        qb.push_back((x == 1) ? expb(1, er) : 7'd0);
        qc.push_back((x == 2) ? expb(2, er) : 7'd0);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rst_cycles(input int n);
        rst = 1'b1;
        va = 4'hf;
        vb = 4'hf;
        vc = 3'h7;
        nf = '0;
        repeat (n) begin
            #1;
            total++;
            if ({ra, rb, rc} !== 11'd0) begin
                bad++;
                $display("FAIL rst_rdys cyc%0d: got a=%b b=%b c=%b want all 0", cyc, ra, rb, rc);
            end
            qa.push_back(7'd0);
            qb.push_back(7'd0);
            qc.push_back(7'd0);
            @(posedge clk);
            #1;
            cyc++;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst_cycles(2);
        step(0, 4'hf, 0, 4'b0001);
        step(0, 4'hf, 0, 4'b0010);
        step(0, 4'hf, 0, 4'b0100);
        step(0, 4'hf, 0, 4'b1000);
        step(0, 4'hf, 0, 4'b0001);
        step(0, 4'hf, 0, 4'b0010);
        step(0, 4'hf, 1, 4'b0000);
        step(0, 4'hf, 1, 4'b0000);
        step(0, 4'hf, 0, 4'b0100);
        step(0, 4'b1001, 0, 4'b1000);
        step(0, 4'b1001, 0, 4'b0001);
        step(0, 4'b0000, 0, 4'b0000);
        repeat (3) step(1, 4'b0011, 0, 4'b0001);
        repeat (3) step(1, 4'b0011, 0, 4'b0010);
        step(1, 4'b0011, 0, 4'b0001);
        step(1, 4'b0000, 0, 4'b0000);
        step(1, 4'b1100, 0, 4'b0100);
        step(1, 4'b1000, 0, 4'b0000);
        step(1, 4'b1000, 0, 4'b1000);
        repeat (5) step(1, 4'hf, 1, 4'b0000);
        step(1, 4'hf, 0, 4'b1000);
        step(1, 4'hf, 0, 4'b1000);
        step(1, 4'hf, 0, 4'b0001);
        rst_cycles(1);
        repeat (3) step(1, 4'b0110, 0, 4'b0010);
        step(1, 4'b0110, 0, 4'b0100);
        step(2, 4'b0100, 0, 4'b0100);
        step(2, 4'b0100, 0, 4'b0100);
        step(2, 4'b0011, 0, 4'b0001);
        step(2, 4'b0111, 0, 4'b0010);
        step(2, 4'b0111, 0, 4'b0100);
        step(2, 4'b0111, 0, 4'b0001);
        step(2, 4'b0000, 0, 4'b0000);
        @(negedge clk);
        #1;
        total++;
        if (qa.size() + qb.size() + qc.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", qa.size() + qb.size() + qc.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
